// File: rtl/dec_chain_if.sv
// Handshake bundle between the control/register logic and the decade-chain
// run/stop controller.
//   master : drives start/pause/clear commands, BCD target and auto_reload;
//            observes count, digit_en, busy, done, err.
//   slave  : the controller side (dec_chain_ctrl).
interface dec_chain_if #(
   parameter int NUM_DIGITS = 3
);
   logic                    start;
   logic                    pause;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] target;
   logic                    auto_reload;
   logic [4*NUM_DIGITS-1:0] count;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    busy;
   logic                    done;
   logic                    err;

   modport master (
      output start, pause, clear, target, auto_reload,
      input  count, digit_en, busy, done, err
   );

   modport slave (
      input  start, pause, clear, target, auto_reload,
      output count, digit_en, busy, done, err
   );
endinterface

// File: rtl/dec_chain_ctrl.sv
// Run/stop controller for a cascade of BCD decade digit counters.
// Counts from a prescaled tick, produces per-digit enable/carry strobes,
// and stops (or wraps to zero) at a programmable BCD target.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous active-high reset, overrides every other input
//   bus    : dec_chain_if.slave
//            start/pause/clear : level commands, priority clear > pause > start
//            target            : BCD terminal value, digit 0 in bits [3:0]
//            auto_reload       : 1 = wrap to 0 at target and keep running
//            count             : current BCD chain value
//            digit_en          : per-digit enable strobes on tick cycles
//            busy              : high in RUN and PAUSE
//            done              : one-cycle pulse on the tick that hits target
//            err               : sticky, start rejected for a non-BCD target
module dec_chain_ctrl #(
   parameter int NUM_DIGITS = 3,
   parameter int PRESCALE   = 4
) (
   input logic        clk,
   input logic        reset,
   dec_chain_if.slave bus
);

   localparam int         CW      = 4 * NUM_DIGITS;
   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t                state;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         target_q;
   logic [15:0]           presc;
   logic                  err_q;

   logic                  tick;
   logic                  at_target;
   logic                  start_ok;
   logic [NUM_DIGITS-1:0] nines_below;
   logic [NUM_DIGITS-1:0] den;
   logic [CW-1:0]         count_inc;

   function automatic logic bcd_valid(input logic [CW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Advance every enabled digit; an enabled 9 rolls over to 0.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0]         v,
                                              input logic [NUM_DIGITS-1:0] en);
      logic [CW-1:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en[i]) r[4*i +: 4] = (v[4*i +: 4] == 4'd9) ? 4'd0 : v[4*i +: 4] + 4'd1;
      end
      return r;
   endfunction

   // nines_below[i] is the carry into digit i: all lower digits sit at 9.
   always_comb begin
      nines_below    = '0;
      nines_below[0] = 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         nines_below[i] = nines_below[i-1] & (count_q[4*(i-1) +: 4] == 4'd9);
      end
   end

   // A tick only fires in RUN when no higher-priority command claims the cycle.
   assign tick      = !reset && (state == RUN) && !bus.clear && !bus.pause && (presc == PS_LAST);
   assign at_target = (count_q == target_q);
   assign den       = {NUM_DIGITS{tick & ~at_target}} & nines_below;
   assign count_inc = bcd_inc(count_q, den);
   assign start_ok  = bcd_valid(bus.target);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count_q  <= '0;
         target_q <= '0;
         presc    <= '0;
         err_q    <= 1'b0;
      end else if (bus.clear) begin
         state   <= IDLE;
         count_q <= '0;
         presc   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (bus.pause) begin
                  state <= PAUSE;
               end else begin
                  presc <= (presc == PS_LAST) ? 16'd0 : presc + 16'd1;
                  if (tick) begin
                     if (!at_target)          count_q <= count_inc;
                     else if (bus.auto_reload) count_q <= '0;
                     else                      state   <= DONE;
                  end
               end
            end
            PAUSE: begin
               // Resume keeps the latched target and the prescaler phase.
               if (!bus.pause && bus.start) state <= RUN;
            end
            default: begin  // IDLE, DONE
               if (!bus.pause && bus.start) begin
                  if (!start_ok) begin
                     err_q <= 1'b1;
                  end else begin
                     target_q <= bus.target;
                     presc    <= '0;
                     state    <= RUN;
                     if (state == DONE) count_q <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign bus.count    = count_q;
   assign bus.digit_en = den;
   assign bus.busy     = (state == RUN) || (state == PAUSE);
   assign bus.done     = tick & at_target;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_dec_chain_ctrl.sv
// Directed bench for dec_chain_ctrl: one instance with PRESCALE=1 and one
// with PRESCALE=4, both three digits wide.
module tb_dec_chain_ctrl;

   logic clk;
   logic rst_a;
   logic rst_b;

   dec_chain_if #(.NUM_DIGITS(3)) ifa ();
   dec_chain_if #(.NUM_DIGITS(3)) ifb ();

   dec_chain_ctrl #(.NUM_DIGITS(3), .PRESCALE(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
   dec_chain_ctrl #(.NUM_DIGITS(3), .PRESCALE(4)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic I1 = 1'b1;
   localparam logic I0 = 1'b0;

   typedef struct {
      logic        st;
      logic        pa;
      logic        cl;
      logic [11:0] tgt;
      logic [11:0] e_cnt;
      logic [2:0]  e_den;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(input logic st, pa, cl, input logic [11:0] tgt,
                               input logic [11:0] ec, input logic [2:0] ed,
                               input logic eb, edn, ee);
      vec_t v;
      v.st = st; v.pa = pa; v.cl = cl; v.tgt = tgt;
      v.e_cnt = ec; v.e_den = ed; v.e_busy = eb; v.e_done = edn; v.e_err = ee;
      return v;
   endfunction

   function automatic logic [11:0] to_bcd(input int n);
      return 12'((((n / 100) % 10) << 8) | (((n / 10) % 10) << 4) | (n % 10));
   endfunction

   // Expected strobes on a tick cycle for a decimal count n against target t.
   function automatic logic [2:0] den_of(input int n, input int t);
      logic [2:0] d;
      d = 3'b000;
      if (n != t) begin
         d[0] = 1'b1;
         d[1] = ((n % 10) == 9);
         d[2] = ((n % 100) == 99);
      end
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, wanted %0h", tag, act, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [11:0] ec, input logic [2:0] ed,
                        input logic eb, input logic edn, input logic ee);
      chk({tag, ".count"},    32'(ifa.count),    32'(ec));
      chk({tag, ".digit_en"}, 32'(ifa.digit_en), 32'(ed));
      chk({tag, ".busy"},     32'(ifa.busy),     32'(eb));
      chk({tag, ".done"},     32'(ifa.done),     32'(edn));
      chk({tag, ".err"},      32'(ifa.err),      32'(ee));
   endtask

   task automatic chk_b(input string tag, input logic [11:0] ec, input logic [2:0] ed,
                        input logic eb, input logic edn);
      chk({tag, ".count"},    32'(ifb.count),    32'(ec));
      chk({tag, ".digit_en"}, 32'(ifb.digit_en), 32'(ed));
      chk({tag, ".busy"},     32'(ifb.busy),     32'(eb));
      chk({tag, ".done"},     32'(ifb.done),     32'(edn));
   endtask

   // Apply inputs on the falling edge, settle, then the caller samples.
   task automatic cyc_a(input logic st, pa, cl, input logic [11:0] tgt, input logic ar);
      @(negedge clk);
      ifa.start = st; ifa.pause = pa; ifa.clear = cl; ifa.target = tgt; ifa.auto_reload = ar;
      #1;
   endtask

   task automatic cyc_b(input logic st, pa, cl, input logic [11:0] tgt, input logic ar);
      @(negedge clk);
      ifb.start = st; ifb.pause = pa; ifb.clear = cl; ifb.target = tgt; ifb.auto_reload = ar;
      #1;
   endtask

   initial begin
      int m;
      logic tk;

      rst_a = 1'b1; rst_b = 1'b1;
      ifa.start = 1'b0; ifa.pause = 1'b0; ifa.clear = 1'b0; ifa.target = '0; ifa.auto_reload = 1'b0;
      ifb.start = 1'b0; ifb.pause = 1'b0; ifb.clear = 1'b0; ifb.target = '0; ifb.auto_reload = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      chk_a("rst_a", 12'h000, 3'b000, I0, I0, I0);
      chk_b("rst_b", 12'h000, 3'b000, I0, I0);

      // Count 000 -> 025 at one step per cycle, then stop in DONE.
      cyc_a(I1, I0, I0, 12'h025, I0);
      chk_a("t1.start", 12'h000, 3'b000, I0, I0, I0);
      for (int n = 0; n <= 25; n++) begin
         cyc_a(I0, I0, I0, 12'h025, I0);
         chk_a($sformatf("t1.n%0d", n), to_bcd(n), den_of(n, 25), I1, (n == 25), I0);
      end
      cyc_a(I0, I0, I0, 12'h025, I0);
      chk_a("t1.done_hold", 12'h025, 3'b000, I0, I0, I0);
      cyc_a(I0, I0, I0, 12'h025, I0);
      chk_a("t1.done_hold2", 12'h025, 3'b000, I0, I0, I0);

      // Carry ripple toward 999, restarting from DONE.
      cyc_a(I1, I0, I0, 12'h999, I0);
      chk_a("t2.start", 12'h025, 3'b000, I0, I0, I0);
      for (int n = 0; n <= 100; n++) begin
         cyc_a(I0, I0, I0, 12'h999, I0);
         chk_a($sformatf("t2.n%0d", n), to_bcd(n), den_of(n, 999), I1, I0, I0);
      end
      cyc_a(I0, I0, I1, 12'h000, I0);
      chk_a("t2.clear", 12'h101, 3'b000, I1, I0, I0);

      // Command table: bad target, priority, pause/resume, DONE restart, target 0.
      tbl[0]  = mk(I1, I0, I0, 12'h0A3, 12'h000, 3'b000, I0, I0, I0);
      tbl[1]  = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I1);
      tbl[2]  = mk(I1, I0, I0, 12'h0A3, 12'h000, 3'b000, I0, I0, I1);
      tbl[3]  = mk(I0, I0, I1, 12'h000, 12'h000, 3'b000, I0, I0, I1);
      tbl[4]  = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I0);
      tbl[5]  = mk(I1, I0, I0, 12'h003, 12'h000, 3'b000, I0, I0, I0);
      tbl[6]  = mk(I0, I0, I0, 12'h000, 12'h000, 3'b001, I1, I0, I0);
      tbl[7]  = mk(I0, I0, I0, 12'h000, 12'h001, 3'b001, I1, I0, I0);
      tbl[8]  = mk(I1, I1, I1, 12'h003, 12'h002, 3'b000, I1, I0, I0);
      tbl[9]  = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I0);
      tbl[10] = mk(I1, I0, I0, 12'h003, 12'h000, 3'b000, I0, I0, I0);
      tbl[11] = mk(I1, I1, I0, 12'h003, 12'h000, 3'b000, I1, I0, I0);
      tbl[12] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I1, I0, I0);
      tbl[13] = mk(I1, I0, I0, 12'h000, 12'h000, 3'b000, I1, I0, I0);
      tbl[14] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b001, I1, I0, I0);
      tbl[15] = mk(I0, I0, I0, 12'h000, 12'h001, 3'b001, I1, I0, I0);
      tbl[16] = mk(I0, I0, I0, 12'h000, 12'h002, 3'b001, I1, I0, I0);
      tbl[17] = mk(I0, I0, I0, 12'h000, 12'h003, 3'b000, I1, I1, I0);
      tbl[18] = mk(I0, I0, I0, 12'h000, 12'h003, 3'b000, I0, I0, I0);
      tbl[19] = mk(I1, I0, I0, 12'h002, 12'h003, 3'b000, I0, I0, I0);
      tbl[20] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b001, I1, I0, I0);
      tbl[21] = mk(I0, I0, I1, 12'h000, 12'h001, 3'b000, I1, I0, I0);
      tbl[22] = mk(I1, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I0);
      tbl[23] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I1, I1, I0);
      tbl[24] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I0);
      tbl[25] = mk(I1, I0, I0, 12'h0A3, 12'h000, 3'b000, I0, I0, I0);
      tbl[26] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I1);
      tbl[27] = mk(I0, I0, I1, 12'h000, 12'h000, 3'b000, I0, I0, I1);
      tbl[28] = mk(I0, I0, I0, 12'h000, 12'h000, 3'b000, I0, I0, I0);
      for (int i = 0; i < 29; i++) begin
         cyc_a(tbl[i].st, tbl[i].pa, tbl[i].cl, tbl[i].tgt, I0);
         chk_a($sformatf("tbl[%0d]", i), tbl[i].e_cnt, tbl[i].e_den,
               tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
      end

      // Reset while running at 017 with a tick in the same cycle.
      cyc_a(I1, I0, I0, 12'h050, I0);
      for (int n = 0; n < 17; n++) cyc_a(I0, I0, I0, 12'h050, I0);
      @(negedge clk);
      rst_a = 1'b1;
      #1;
      chk("t6.pre_count", 32'(ifa.count), 32'h017);
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      chk_a("t6.after", 12'h000, 3'b000, I0, I0, I0);

      // PRESCALE=4, target 003 with auto-reload.
      cyc_b(I1, I0, I0, 12'h003, I1);
      chk_b("t3.start", 12'h000, 3'b000, I0, I0);
      m = 0;
      for (int k = 1; k <= 24; k++) begin
         cyc_b(I0, I0, I0, 12'h003, I1);
         tk = ((k % 4) == 0);
         chk_b($sformatf("t3.k%0d", k), to_bcd(m), tk ? den_of(m, 3) : 3'b000, I1, tk && (m == 3));
         if (tk) m = (m == 3) ? 0 : m + 1;
      end
      cyc_b(I0, I0, I1, 12'h000, I0);
      chk_b("t3.clear", to_bcd(m), 3'b000, I1, I0);
      cyc_b(I0, I0, I0, 12'h000, I0);
      chk_b("t3.idle", 12'h000, 3'b000, I0, I0);

      // Pause at 005 on a tick-due cycle; target changes while paused.
      cyc_b(I1, I0, I0, 12'h050, I0);
      m = 0;
      for (int k = 1; k <= 23; k++) begin
         cyc_b(I0, I0, I0, 12'h050, I0);
         tk = ((k % 4) == 0);
         chk_b($sformatf("t4.k%0d", k), to_bcd(m), tk ? den_of(m, 50) : 3'b000, I1, I0);
         if (tk) m = m + 1;
      end
      cyc_b(I0, I1, I0, 12'h050, I0);
      chk_b("t4.pause0", 12'h005, 3'b000, I1, I0);
      for (int k = 1; k < 10; k++) begin
         cyc_b(I0, I1, I0, 12'h006, I0);
         chk_b($sformatf("t4.pause%0d", k), 12'h005, 3'b000, I1, I0);
      end
      cyc_b(I1, I0, I0, 12'h006, I0);
      chk_b("t4.resume", 12'h005, 3'b000, I1, I0);
      cyc_b(I0, I0, I0, 12'h006, I0);
      chk_b("t4.held_phase_tick", 12'h005, 3'b001, I1, I0);
      for (int k = 0; k < 3; k++) begin
         cyc_b(I0, I0, I0, 12'h006, I0);
         chk_b($sformatf("t4.gap%0d", k), 12'h006, 3'b000, I1, I0);
      end
      cyc_b(I0, I0, I0, 12'h006, I0);
      chk_b("t4.old_target", 12'h006, 3'b001, I1, I0);
      cyc_b(I0, I0, I0, 12'h006, I0);
      chk_b("t4.next", 12'h007, 3'b000, I1, I0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
